tent_sweep_ctrl: RTL and testbench

Sequencer that sits directly in front of and behind tentCycle, which iterates the tent map. It sweeps mu across a programmed range, and for each point resets tentCycle with a fixed x0 and iteration count, waits for done, and captures the result. Each (mu, result) pair is pushed into an output FIFO with valid/ready handshake. It produces bifurcation-diagram data for the downstream readout logic.

---
 rtl/tent_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/tent_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tent_sweep_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tent_pkg.sv
// Shared types for the tent-map sweep sequencer: FSM states, widths and the
// (mu, result, last) record that travels through the output FIFO.
package tent_pkg;

    localparam int DATA_W = 16;
    localparam int ITER_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET    = 3'd1,
        RUN    = 3'd2,
        PUSH   = 3'd3,
        FINISH = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] mu;
        logic [DATA_W-1:0] data;
        logic              last;
    } sweep_entry_t;

    // tentCycle compares its ITER_W-bit counter against times, so anything
    // above the ceiling would never match and the point would hang forever.
    function automatic logic [DATA_W-1:0] clamp_iter(
        input logic [DATA_W-1:0] req,
        input logic [DATA_W-1:0] ceiling
    );
        return (req > ceiling) ? ceiling : req;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is on rd_data whenever
// empty=0. A write while full is accepted only if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/tent_sweep_ctrl.sv
// Sweeps mu over a programmed range, runs tentCycle once per point and queues
// each (mu, result, last) record into a FWFT output FIFO for the readout logic.
module tent_sweep_ctrl
    import tent_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_ITER   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] mu_start,
    input  logic [15:0] mu_step,
    input  logic [15:0] n_points,
    input  logic [15:0] x0_cfg,
    input  logic [15:0] iter_cfg,
    output logic        busy,
    output logic        cyc_dset,
    output logic [15:0] cyc_dzero,
    output logic [15:0] cyc_times,
    output logic [15:0] cyc_mu,
    input  logic        cyc_done,
    input  logic [15:0] cyc_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_mu,
    output logic [15:0] out_data,
    output logic        out_last
);

    localparam logic [DATA_W-1:0] ITER_CEIL = DATA_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mu_q, mu_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] x0_q, x0_d;
    logic [DATA_W-1:0] times_q, times_d;
    logic [DATA_W-1:0] remain_q, remain_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              dset_q, dset_d;

    sweep_entry_t      push_entry;
    sweep_entry_t      head_entry;
    logic              fifo_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_ok;
    logic              is_last;

    assign is_last = (remain_q == DATA_W'(1));
    assign pop     = ~fifo_empty & out_ready;
    // A full FIFO still takes the new record when the head leaves this cycle.
    assign push_ok = ~fifo_full | pop;

    assign push_entry.mu   = mu_q;
    assign push_entry.data = result_q;
    assign push_entry.last = is_last;

    always_comb begin
        state_d  = state_q;
        mu_d     = mu_q;
        step_d   = step_q;
        x0_d     = x0_q;
        times_d  = times_q;
        remain_d = remain_q;
        result_d = result_q;
        busy_d   = busy_q;
        dset_d   = dset_q;
        fifo_wr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mu_d     = mu_start;
                    step_d   = mu_step;
                    x0_d     = x0_cfg;
                    times_d  = clamp_iter(iter_cfg, ITER_CEIL);
                    remain_d = n_points;
                    if (n_points != '0) begin
                        state_d = SET;
                        busy_d  = 1'b1;
                        dset_d  = 1'b1;
                    end
                end
            end
            SET: begin
                state_d = RUN;
                dset_d  = 1'b0;
            end
            RUN: begin
                // Dset clears done asynchronously, so the first sample here is trustworthy.
                if (cyc_done) begin
                    result_d = cyc_result;
                    state_d  = PUSH;
                end
            end
            PUSH: begin
                if (push_ok) begin
                    fifo_wr = 1'b1;
                    dset_d  = 1'b1;
                    if (is_last) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                    end else begin
                        mu_d     = mu_q + step_q;
                        remain_d = remain_q - DATA_W'(1);
                        state_d  = SET;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dset_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            mu_q     <= '0;
            step_q   <= '0;
            x0_q     <= '0;
            times_q  <= '0;
            remain_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            dset_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            mu_q     <= mu_d;
            step_q   <= step_d;
            x0_q     <= x0_d;
            times_q  <= times_d;
            remain_q <= remain_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            dset_q   <= dset_d;
        end
    end

    assign busy      = busy_q;
    assign cyc_dset  = dset_q;
    assign cyc_dzero = x0_q;
    assign cyc_times = times_q;
    assign cyc_mu    = mu_q;

    sync_fifo #(
        .WIDTH ($bits(sweep_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (fifo_wr),
        .wr_data (push_entry),
        .rd_en   (out_ready),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_mu    = head_entry.mu;
    assign out_data  = head_entry.data;
    assign out_last  = head_entry.last & ~fifo_empty;

endmodule

// File: tb/tb_tent_sweep_ctrl.sv
// Bench for tent_sweep_ctrl: a tentCycle stand-in drives the cycle interface,
// and a sweep-level model predicts every record popped from the output FIFO.
module tb_tent_sweep_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int MAX_ITER   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mu_start, mu_step, n_points, x0_cfg, iter_cfg;
    logic        busy, cyc_dset;
    logic [15:0] cyc_dzero, cyc_times, cyc_mu;
    logic        cyc_done;
    logic [15:0] cyc_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_mu, out_data;
    logic        out_last;

    int tests = 0;
    int fails = 0;
    int ready_mode = 1;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    tent_sweep_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_ITER(MAX_ITER)) dut (
        .CLK(clk), .RST(rst), .start(start),
        .mu_start(mu_start), .mu_step(mu_step), .n_points(n_points),
        .x0_cfg(x0_cfg), .iter_cfg(iter_cfg), .busy(busy),
        .cyc_dset(cyc_dset), .cyc_dzero(cyc_dzero), .cyc_times(cyc_times),
        .cyc_mu(cyc_mu), .cyc_done(cyc_done), .cyc_result(cyc_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_mu(out_mu),
        .out_data(out_data), .out_last(out_last)
    );

    function automatic logic [15:0] tent_step(input logic [15:0] mu, input logic [15:0] x);
        logic [31:0] p;
        if (x < 16'h8000) p = {16'h0, mu} * {16'h0, x};
        else              p = {16'h0, mu} * {16'h0, 16'hFFFF - x};
        return p[15:0];
    endfunction

    function automatic logic [15:0] tent_run(input logic [15:0] mu, input logic [15:0] x0, input int t);
        logic [15:0] x;
        x = x0;
        for (int i = 0; i < t; i++) x = tent_step(mu, x);
        return x;
    endfunction

    // tentCycle stand-in: loads on Dset, done is cleared while Dset is high.
    logic [15:0] stub_x   = 16'h0;
    int          stub_cnt = 0;
    always @(posedge clk) begin
        if (cyc_dset) begin
            stub_x   <= cyc_dzero;
            stub_cnt <= 0;
        end else if (stub_cnt < int'(cyc_times)) begin
            stub_x   <= tent_step(cyc_mu, stub_x);
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign cyc_done   = !cyc_dset && (stub_cnt == int'(cyc_times));
    assign cyc_result = stub_x;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1)      out_ready = 1'b1;
        else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else                      out_ready = 1'b0;
    end

    // Compare process: every pop against the model, and head stability under backpressure.
    logic        prev_hold = 1'b0;
    logic [32:0] prev_head = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {32'h0, out_valid}, 33'h1);
                chk("hold_head", {out_mu, out_data, out_last}, prev_head);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {out_mu, out_data, out_last}, 33'h0_0000_0000 ^ {out_mu, out_data, ~out_last});
                end else begin
                    chk("pop_entry", {out_mu, out_data, out_last}, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_head = {out_mu, out_data, out_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] mu, input logic [15:0] step, input logic [15:0] n,
                            input logic [15:0] x0, input logic [15:0] iter, input bit accept);
        logic [15:0] m;
        int t;
        t = (int'(iter) > MAX_ITER) ? MAX_ITER : int'(iter);
        tick();
        mu_start = mu; mu_step = step; n_points = n; x0_cfg = x0; iter_cfg = iter;
        start = 1'b1;
        tick();
        start = 1'b0;
        mu_start = 16'($urandom); mu_step = 16'($urandom); n_points = 16'($urandom);
        x0_cfg = 16'($urandom); iter_cfg = 16'($urandom);
        if (accept) begin
            m = mu;
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back({m, tent_run(m, x0, t), (i == int'(n) - 1)});
                m = m + step;
            end
        end
        @(negedge clk);
        if (accept) begin
            chk("busy_after_start", {32'h0, busy}, {32'h0, (n != 16'h0)});
            if (n != 16'h0) begin
                chk("set_dset", {32'h0, cyc_dset}, 33'h1);
                chk("set_mu", {17'h0, cyc_mu}, {17'h0, mu});
                chk("set_dzero", {17'h0, cyc_dzero}, {17'h0, x0});
                chk("set_times", {17'h0, cyc_times}, 33'(t));
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || out_valid || exp_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_budget", {32'h0, (k < budget)}, 33'h1);
        if (k >= budget) exp_q.delete();
    endtask

    task automatic check_latency(input string name, input int exp_k);
        int k = 1;
        while (!out_valid && k < exp_k + 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 33'(k), 33'(exp_k));
        chk({name, "_busy_low"}, {32'h0, busy}, 33'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        mu_start = '0; mu_step = '0; n_points = '0; x0_cfg = '0; iter_cfg = '0;
        ready_mode = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {32'h0, busy}, 33'h0);
        chk("rst_dset", {32'h0, cyc_dset}, 33'h1);
        chk("rst_cyc_fields", {1'b0, cyc_dzero | cyc_times | cyc_mu}, 33'h0);
        chk("rst_out_valid", {32'h0, out_valid}, 33'h0);
        chk("rst_out_last", {32'h0, out_last}, 33'h0);
        rst = 1'b0;

        chk("model_iter1", {17'h0, tent_run(16'h0002, 16'h4000, 1)}, {17'h0, 16'h8000});
        chk("model_fold", {17'h0, tent_run(16'h0002, 16'h4000, 2)}, {17'h0, 16'hFFFE});
        chk("model_wrap", {17'h0, tent_run(16'h0004, 16'h4000, 1)}, {17'h0, 16'h0000});

        // single point
        do_start(16'h0002, 16'h0000, 16'd1, 16'h4000, 16'd1, 1'b1);
        check_latency("single_latency", 5);
        wait_idle(200);

        // fold branch
        do_start(16'h0002, 16'h0000, 16'd1, 16'h4000, 16'd2, 1'b1);
        wait_idle(200);

        // three-point sweep, records pinned literally
        do_start(16'h0002, 16'h0001, 16'd3, 16'h4000, 16'd1, 1'b1);
        chk("sweep_rec0", exp_q[0], {16'h0002, 16'h8000, 1'b0});
        chk("sweep_rec1", exp_q[1], {16'h0003, 16'hC000, 1'b0});
        chk("sweep_rec2", exp_q[2], {16'h0004, 16'h0000, 1'b1});
        wait_idle(200);

        // iteration clamp
        do_start(16'h0002, 16'h0000, 16'd1, 16'h1234, 16'h0300, 1'b1);
        check_latency("clamp_latency", MAX_ITER + 4);
        wait_idle(600);

        // zero iterations: x0 passes through untouched
        do_start(16'h0002, 16'h0000, 16'd1, 16'h4000, 16'd0, 1'b1);
        chk("zero_rec", exp_q[0], {16'h0002, 16'h4000, 1'b1});
        check_latency("zero_latency", 4);
        wait_idle(200);

        // n_points = 0
        do_start(16'h0005, 16'h0001, 16'd0, 16'h4000, 16'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("n0_busy", {32'h0, busy}, 33'h0);
            chk("n0_valid", {32'h0, out_valid}, 33'h0);
        end

        // backpressure: FIFO fills, FSM stalls, then drains in order
        ready_mode = 0;
        do_start(16'h0100, 16'h0003, 16'(FIFO_DEPTH + 2), 16'h2345, 16'd0, 1'b1);
        repeat (60) @(negedge clk);
        chk("bp_stall_busy", {32'h0, busy}, 33'h1);
        chk("bp_stall_valid", {32'h0, out_valid}, 33'h1);
        chk("bp_head", {out_mu, out_data, out_last}, exp_q[0]);
        ready_mode = 1;
        wait_idle(400);

        // start while busy is ignored
        ready_mode = 2;
        do_start(16'h0005, 16'h0007, 16'd3, 16'h1111, 16'd12, 1'b1);
        repeat (5) @(negedge clk);
        do_start(16'h9999, 16'h0001, 16'd5, 16'h2222, 16'd3, 1'b0);
        wait_idle(400);

        // async reset mid-RUN with entries queued
        ready_mode = 0;
        do_start(16'h0003, 16'h0001, 16'd4, 16'h3000, 16'd5, 1'b1);
        repeat (14) @(negedge clk);
        chk("pre_reset_valid", {32'h0, out_valid}, 33'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {32'h0, out_valid}, 33'h0);
        chk("rst_mid_busy", {32'h0, busy}, 33'h0);
        chk("rst_mid_dset", {32'h0, cyc_dset}, 33'h1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        chk("post_rst_valid", {32'h0, out_valid}, 33'h0);
        do_start(16'h0002, 16'h0001, 16'd3, 16'h4000, 16'd1, 1'b1);
        wait_idle(300);

        // randomized sweeps with random consumer stalls
        ready_mode = 2;
        for (int s = 0; s < 10; s++) begin
            logic [15:0] it;
            logic [15:0] np;
            if (s % 5 == 4) begin
                it = 16'($urandom_range(250, 300));
                np = 16'($urandom_range(1, 2));
            end else begin
                it = 16'($urandom_range(0, 15));
                np = 16'($urandom_range(1, 12));
            end
            do_start(16'($urandom), 16'($urandom), np, 16'($urandom), it, 1'b1);
            wait_idle(8000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
